// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage buffers of the LoongArch pipeline.
// Holds the stage state encoding and the architectural constants used to build bubbles.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    // andi r0,r0,0 -- the canonical NOP, used as the IF/ID bubble payload
    localparam logic [31:0] NOP_INST = 32'h0340_0000;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    function automatic logic [1:0] occ_of_state(input pipe_state_t st);
        case (st)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: opaque W-bit payload under valid/ready, synchronous flush to bubble.
// SKID=1 adds a second entry so that in_ready comes straight from a flop.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned     W      = 32,
    parameter logic [W-1:0]    BUBBLE = '0,
    parameter bit              SKID   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    pipe_state_t  state_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_fire;
    logic         out_fire;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_valid = (state_q != ST_EMPTY);
    // main_q is reloaded with BUBBLE whenever the stage empties, so out_data stays a plain flop
    assign out_data  = main_q;
    assign occupancy = occ_of_state(state_q);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_data;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire && SKID) begin
                        skid_q  <= in_data;
                        state_q <= ST_FULL;
                    end else if (out_fire) begin
                        main_q  <= BUBBLE;
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        state_q <= ST_BUSY;
                    end
                end
                default: begin
                    main_q  <= BUBBLE;
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    generate
        if (SKID) begin : g_skid
            logic rdy_q;
            logic full_d;

            // Registered ready tracks whether the stage will hold two entries next cycle
            assign full_d = (state_q == ST_BUSY && in_fire && !out_fire) ||
                            (state_q == ST_FULL && !out_fire);

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= !full_d;
                end
            end

            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline stage that replaces the fixed-field inter-stage registers of the LoongArch pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque W-bit payload under a valid/ready handshake, with a synchronous flush that converts the stage to a bubble. An optional second (skid) entry registers the upstream ready path. Stalls are expressed as downstream back-pressure instead of a separate stall pin.

## Interface
- W, 32, payload width in bits (≥1); each pipeline boundary concatenates its fields into this bus.
- BUBBLE, {W{1'b0}}, payload driven on out_data whenever the stage is empty (reset, flush, drained).
- SKID, 1, 1 = two-entry buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready.
- in_data  in  W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_data  out  W  head payload, registered.
- occupancy  out  2  number of live entries (0..2), for the hazard unit and for debug.

## Operation
- States: EMPTY (0 entries), BUSY (main entry live), FULL (main + skid live; SKID=1 only).
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- EMPTY: in_fire → main<=in_data, BUSY. Otherwise stay in EMPTY.
- BUSY, in_fire && out_fire → main<=in_data, stay in BUSY. in_fire only → SKID=1: skid<=in_data, FULL (SKID=0 cannot reach this branch). out_fire only → EMPTY.
- FULL: in_ready=0. out_fire → main<=skid, BUSY. Otherwise hold.
- in_ready: SKID=1 → registered, 1 in EMPTY and BUSY, 0 in FULL. SKID=0 → !out_valid || out_ready (combinational).
- out_valid = (state != EMPTY). out_data = main when valid, BUBBLE when EMPTY.
- Order is preserved: the skid entry is always younger than the main entry.
- Priority: rst > flush > handshake.
- Flush: next state is EMPTY, out_data=BUBBLE, occupancy=0. An in_fire in the flush cycle is discarded. An out_fire in the flush cycle counts as delivered, because downstream sampled it.
- While out_valid && !out_ready, out_data and out_valid remain stable until out_fire or flush.
- Payload is not interpreted. Commit, PC and control bits are opaque fields of in_data.

## Timing
- Reset values: out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1 (both SKID settings), state EMPTY.
- Latency: 1 cycle from in_fire to out_valid/out_data.
- Throughput: 1 transfer/cycle sustained under continuous out_ready=1.
- SKID=1: in_ready deasserts the cycle after the stage becomes FULL, and reasserts the cycle after the FULL→BUSY drain. There is no combinational path from out_ready to in_ready.
- SKID=0: there is a combinational path out_ready → in_ready. Other outputs are registered.
- The first cycle after flush or rst shows out_valid=0 and in_ready=1. An in_valid in that cycle is accepted.
- rst asserted mid-FULL discards both entries. There is no partial drain.

## Structure
- Shared package pipe_pkg:
  - state typedef pipe_state_t {ST_EMPTY, ST_BUSY, ST_FULL}.
  - Constant NOP_INST = 32'h0340_0000 (andi r0,r0,0), for IF/ID BUBBLE construction.
  - Constant RESET_PC = 32'h1c00_0000.
- Single module. No sub-module is warranted: main and skid are two W-bit registers plus a 2-bit state register.
- Boundary-specific field packing and unpacking lives in the pipeline top, not here.

## Test plan
- Reset, W=32, BUBBLE=32'h0340_0000: hold rst 2 cycles → out_valid=0, out_data=32'h0340_0000, in_ready=1, occupancy=0.
- Streaming, SKID=1, out_ready=1: present 0x1,0x2,0x3 on consecutive cycles → out_data shows 0x1,0x2,0x3 one cycle later each, with no gaps.
- Back-pressure, SKID=1:
  - Accept 0xA, then hold out_ready=0 and present 0xB → FULL, in_ready=0, out_data stays 0xA.
  - Raise out_ready → 0xA then 0xB delivered in order, and in_ready=1 the cycle after the drain.
- SKID=0, out_ready=0 with 0xC held → in_ready=0 in the same cycle. Raising out_ready with 0xD presented → in_ready=1 combinationally, and 0xD appears next cycle.
- Flush while FULL, with in_valid=1 carrying 0xE → next cycle out_valid=0, out_data=BUBBLE, occupancy=0, and 0xE never appears.
- rst and flush asserted together mid-stream, with out_ready toggling randomly → reset values result. A scoreboard then confirms order and no loss or duplication over 1000 random transfers.
